// File: rtl/instr_fetch_unit.sv
// Sequential PC-addressed fetch from a packed instruction stream with valid/ready output,
// redirect, end-of-memory halt, misalignment fault and saturating transfer counter.
// Optional build macro ZERO_HALT_EN: a loaded all-zero word ends the program.
module instr_fetch_unit #(
    parameter int MEM_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [32*MEM_WORDS-1:0] instruction_stream,
    input  logic                    start,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_pc,
    output logic                    halted,
    output logic                    fault,
    output logic [CNT_W-1:0]        fetch_count
);

    localparam int          IDX_W        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] MEM_WORDS_32 = 32'(MEM_WORDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [31:0]        pc_r, pc_nxt_s;
    logic               out_valid_r, out_valid_nxt_s;
    logic [31:0]        out_instr_r, out_instr_nxt_s;
    logic [31:0]        out_pc_r, out_pc_nxt_s;
    logic               halted_r, halted_nxt_s;
    logic               fault_r, fault_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;

    logic [31:0]        mem_s [MEM_WORDS];
    logic [29:0]        word_idx_s;
    logic               in_range_s;
    logic               redir_in_range_s;
    logic [31:0]        rd_word_s;
    logic               load_s;
    logic               xfer_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    for (genvar k = 0; k < MEM_WORDS; k++) begin : g_word
        assign mem_s[k] = instruction_stream[32*k +: 32];
    end

    assign word_idx_s       = pc_r[31:2];
    assign in_range_s       = ({2'b00, word_idx_s} < MEM_WORDS_32);
    assign redir_in_range_s = ({2'b00, redirect_pc[31:2]} < MEM_WORDS_32);
    assign load_s           = !out_valid_r || out_ready;
    assign xfer_s           = out_valid_r && out_ready;

    // Combinational read of the addressed word; out-of-range reads as zero
    always_comb begin
        rd_word_s = 32'h0000_0000;
        if (in_range_s) begin
            rd_word_s = mem_s[word_idx_s[IDX_W-1:0]];
        end else begin
            rd_word_s = 32'h0000_0000;
        end
    end

    // Next-state and next-output logic for the fetch FSM
    always_comb begin
        state_nxt_s     = state_r;
        pc_nxt_s        = pc_r;
        out_valid_nxt_s = out_valid_r;
        out_instr_nxt_s = out_instr_r;
        out_pc_nxt_s    = out_pc_r;
        halted_nxt_s    = halted_r;
        fault_nxt_s     = fault_r;
        count_nxt_s     = count_r;

        // Counting is independent of redirect so a coincident transfer is never lost
        if (xfer_s) begin
            count_nxt_s = sat_inc(count_r);
        end else begin
            count_nxt_s = count_r;
        end

        case (state_r)
            IDLE: begin
                out_valid_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s = FETCH;
                    pc_nxt_s    = 32'h0000_0000;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    out_valid_nxt_s = 1'b0;
                    pc_nxt_s        = redirect_pc;
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_nxt_s  = 1'b1;
                        halted_nxt_s = 1'b1;
                        state_nxt_s  = HALT;
                    end else if (!redir_in_range_s) begin
                        halted_nxt_s = 1'b1;
                        state_nxt_s  = HALT;
                    end else begin
                        state_nxt_s  = FETCH;
                    end
                end else if (load_s) begin
                    if (!in_range_s) begin
                        out_valid_nxt_s = 1'b0;
                        halted_nxt_s    = 1'b1;
                        state_nxt_s     = HALT;
`ifdef ZERO_HALT_EN
                    end else if (rd_word_s == 32'h0000_0000) begin
                        out_valid_nxt_s = 1'b0;
                        halted_nxt_s    = 1'b1;
                        state_nxt_s     = HALT;
`endif
                    end else begin
                        out_valid_nxt_s = 1'b1;
                        out_instr_nxt_s = rd_word_s;
                        out_pc_nxt_s    = pc_r;
                        pc_nxt_s        = pc_r + 32'd4;
                    end
                end else begin
                    out_valid_nxt_s = out_valid_r;
                end
            end
            HALT: begin
                out_valid_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s  = FETCH;
                    pc_nxt_s     = 32'h0000_0000;
                    halted_nxt_s = 1'b0;
                    fault_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s  = HALT;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                out_valid_nxt_s = 1'b0;
                halted_nxt_s    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            pc_r        <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_instr_r <= 32'h0000_0000;
            out_pc_r    <= 32'h0000_0000;
            halted_r    <= 1'b0;
            fault_r     <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_instr_r <= out_instr_nxt_s;
            out_pc_r    <= out_pc_nxt_s;
            halted_r    <= halted_nxt_s;
            fault_r     <= fault_nxt_s;
            count_r     <= count_nxt_s;
        end
    end

    assign out_valid   = out_valid_r;
    assign out_instr   = out_instr_r;
    assign out_pc      = out_pc_r;
    assign halted      = halted_r;
    assign fault       = fault_r;
    assign fetch_count = count_r;

endmodule
